clk_div_ctrl: RTL and testbench
===============================

// Module: clk_div_ctrl
// PURPOSE
//   Run-time programmable divide-by-N clock generator with controller. It generalises the
//   fixed divide-by-3, 50%-duty divider to any N >= 2 and sequences start, stop and
//   ratio changes through a valid/ready config port.
//   Changes take effect only at period boundaries, so div_out never glitches or emits a
//   runt pulse. Feeds peripheral clock-enable / baud logic.
// PARAMETERS
//   CNT_W      8   width of divisor and phase counter; legal N = 2 .. 2**CNT_W-1
//   DIV_RESET  3   divisor loaded at reset (not running)
// PORTS
//   clk        in   1      clock; all logic rising-edge except the one falling-edge phase flop
//   reset      in   1      synchronous, active-high
//   cfg_valid  in   1      config request valid
//   cfg_ready  out  1      controller can accept config this cycle
//   cfg_en     in   1      1 = run with cfg_div, 0 = stop
//   cfg_div    in   CNT_W  requested divisor N
//   cfg_err    out  1      one-cycle pulse: accepted request had N < 2 (ignored)
//   div_out    out  1      divided clock, 50% duty (odd N: high N/2 cycles via falling-edge phase)
//   div_tick   out  1      one-cycle pulse on last cycle of each period (cnt == N-1)
//   busy       out  1      high whenever state != IDLE
// BEHAVIOUR
//   Reset (sampled at rising edge): state=IDLE, cnt=0, cur_div=DIV_RESET, q_pos=0, all outputs 0.
//   Reset (sampled at falling edge): q_neg=0. cfg_ready is forced 0 while reset=1.
//   Handshake: transfer when cfg_valid & cfg_ready. cfg_ready = 1 in IDLE and RUN, 0 in PEND/DRAIN.
//     Inputs may change freely while cfg_ready=0.
//   Illegal N (0 or 1) with cfg_en=1: request consumed, cfg_err=1 the next cycle, no state change.
//   Phase gen: H = cur_div>>1. q_pos <= (cnt_next < H). q_neg captures q_pos on the falling edge.
//     div_out = q_pos | (cur_div[0] & q_neg).
//   Counter: cnt counts 0..cur_div-1 and wraps. It only runs in RUN, PEND and DRAIN.
//   States:
//     IDLE  accept en=1 -> load cur_div, cnt=0 next cycle, RUN. div_out rises 1 cycle after accept.
//           accept en=0 -> stay IDLE, no effect.
//     RUN   accept en=1 at cnt!=N-1 -> pend_div=cfg_div, PEND.
//           accept en=1 at cnt==N-1 -> new N used from the next cycle (cnt=0), stay RUN.
//           accept en=0 at cnt!=N-1 -> DRAIN.
//           accept en=0 at cnt==N-1 -> IDLE next cycle.
//     PEND  at cnt==N-1: cur_div<=pend_div, cnt<=0 -> RUN.
//     DRAIN at cnt==N-1: cnt<=0 -> IDLE, div_out held 0.
//   div_tick is asserted in RUN, PEND and DRAIN whenever cnt==cur_div-1.
//   Old period always completes. Every high pulse has its full length for its own N.
//   Reset mid-period: back to IDLE at that edge. div_out is 0 no later than the next falling edge.
//   N=2: H=1, even, so div_out toggles every cycle. N=2**CNT_W-1 requires no overflow
//     (cnt max = N-1).
// STRUCTURE
//   clk_div_pkg: state enum {IDLE,RUN,PEND,DRAIN}, localparam MIN_DIV=2.
//   Sub-module clk_div_core: cnt, q_pos, q_neg, div_out, div_tick. Inputs: run, load, div.
//   Top level holds the FSM, pend_div, the handshake and cfg_err.
// TESTING
//   1 reset; accept N=3 en=1 -> div_out period 3 clk, high 1.5 clk; div_tick every 3rd cycle.
//   2 RUN N=4; accept N=5 at cnt=1 -> cfg_ready=0 until boundary; 4-cycle period completes,
//     then 5-cycle periods start with 2.5-cycle high.
//   3 RUN N=6; accept en=0 at cnt=2 -> DRAIN, period finishes, then IDLE; busy falls, div_out=0.
//   4 accept N=1 en=1 in IDLE -> cfg_err pulses 1 cycle, busy stays 0, div_out stays 0.
//   5 RUN N=2 -> div_out toggles each cycle. RUN N=255 (CNT_W=8) -> tick every 255, high 127.5.
//   6 assert reset mid-PEND (N=7, pend 3) -> IDLE, pend discarded; restart with N=3 -> period 3.

Source files
------------

// File: rtl/clk_div_ctrl_pkg.sv
// clk_div_pkg: shared types and constants for the programmable clock divider.
//   state_t / IDLE..DRAIN : controller state encoding
//   MIN_DIV               : smallest legal divisor
package clk_div_pkg;
  typedef logic [1:0] state_t;
  localparam state_t IDLE  = 2'd0;
  localparam state_t RUN   = 2'd1;
  localparam state_t PEND  = 2'd2;
  localparam state_t DRAIN = 2'd3;

  localparam int MIN_DIV = 2;
endpackage

// File: rtl/clk_div_ctrl_if.sv
// clk_div_ctrl_if: valid/ready configuration port of the clock divider.
//   cfg_valid / cfg_ready : handshake, transfer on both high at rising clk
//   cfg_en                : 1 = run with cfg_div, 0 = stop
//   cfg_div               : requested divisor N
//   cfg_err               : one-cycle pulse after an accepted illegal N
interface clk_div_ctrl_if #(parameter int CNT_W = 8);
  logic             cfg_valid;
  logic             cfg_ready;
  logic             cfg_en;
  logic [CNT_W-1:0] cfg_div;
  logic             cfg_err;

  modport master (output cfg_valid, cfg_en, cfg_div, input cfg_ready, cfg_err);
  modport slave  (input cfg_valid, cfg_en, cfg_div, output cfg_ready, cfg_err);
endinterface

// File: rtl/clk_div_ctrl_core.sv
// clk_div_core: phase counter and 50%-duty output stage.
//   clk, reset : clock, synchronous active-high reset
//   run        : counter active after this edge (0 parks cnt at 0, output low)
//   load       : start a fresh period with divisor div at this edge
//   div        : divisor to load
//   last       : cnt == cur_div-1 (raw, for the controller)
//   div_out    : divided clock
//   div_tick   : last cycle of each running period
module clk_div_core
  import clk_div_pkg::*;
#(
  parameter int CNT_W     = 8,
  parameter int DIV_RESET = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             load,
  input  logic [CNT_W-1:0] div,
  output logic             last,
  output logic             div_out,
  output logic             div_tick
);
  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt, cnt_nxt, cur_div, div_nxt;
  logic             running, q_pos, q_neg;

  assign last    = (cnt == cur_div - ONE);
  assign div_nxt = load ? div : cur_div;
  // cnt never exceeds N-1, so N = 2**CNT_W-1 cannot overflow.
  assign cnt_nxt = (!run || load || last) ? '0 : cnt + ONE;

  // q_pos is registered from the next count so it is aligned with cnt:
  // high for cnt in [0, H).
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      cur_div <= DIV_RESET[CNT_W-1:0];
      q_pos   <= 1'b0;
      running <= 1'b0;
    end else begin
      cnt     <= cnt_nxt;
      cur_div <= div_nxt;
      q_pos   <= run & (cnt_nxt < (div_nxt >> 1));
      running <= run;
    end
  end

  // Half-cycle extension for odd N. q_pos is always 0 on the last cycle of a
  // period (N-1 >= H), so q_neg is 0 whenever cur_div changes: no runt pulse.
  always_ff @(negedge clk) begin
    if (reset) q_neg <= 1'b0;
    else       q_neg <= q_pos;
  end

  assign div_out  = q_pos | (cur_div[0] & q_neg);
  assign div_tick = running & last;
endmodule

// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: run-time programmable divide-by-N clock generator.
//   clk, reset : clock, synchronous active-high reset
//   cfg        : config port (start / stop / ratio change), slave side
//   div_out    : divided clock, 50% duty
//   div_tick   : one-cycle pulse on last cycle of each period
//   busy       : controller not idle
// All changes land on period boundaries; a ratio change mid-period is parked
// in pend_div (PEND), a stop mid-period lets the period finish (DRAIN).
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int CNT_W     = 8,
  parameter int DIV_RESET = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  clk_div_ctrl_if.slave        cfg,
  output logic                 div_out,
  output logic                 div_tick,
  output logic                 busy
);
  state_t           state, state_nxt;
  logic [CNT_W-1:0] pend_div, ld_div;
  logic             acc, legal, last, run, load, pend_ld, err;

  assign cfg.cfg_ready = ~reset & (state == IDLE || state == RUN);
  assign acc           = cfg.cfg_valid & cfg.cfg_ready;
  assign legal         = cfg.cfg_div >= CNT_W'(MIN_DIV);

  always_comb begin
    state_nxt = state;
    run       = 1'b1;
    load      = 1'b0;
    pend_ld   = 1'b0;
    ld_div    = cfg.cfg_div;
    case (state)
      IDLE: begin
        run = 1'b0;
        if (acc && cfg.cfg_en && legal) begin
          run       = 1'b1;
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (acc) begin
          if (cfg.cfg_en) begin
            if (legal) begin
              if (last) load = 1'b1;
              else begin
                pend_ld   = 1'b1;
                state_nxt = PEND;
              end
            end
          end else if (last) begin
            run       = 1'b0;
            state_nxt = IDLE;
          end else begin
            state_nxt = DRAIN;
          end
        end
      end
      PEND: begin
        if (last) begin
          load      = 1'b1;
          ld_div    = pend_div;
          state_nxt = RUN;
        end
      end
      DRAIN: begin
        if (last) begin
          run       = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: begin
        run       = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      pend_div <= '0;
      err      <= 1'b0;
    end else begin
      state <= state_nxt;
      if (pend_ld) pend_div <= cfg.cfg_div;
      err   <= acc & cfg.cfg_en & ~legal;
    end
  end

  assign cfg.cfg_err = err;
  assign busy        = (state != IDLE);

  clk_div_core #(.CNT_W(CNT_W), .DIV_RESET(DIV_RESET)) u_core (
    .clk      (clk),
    .reset    (reset),
    .run      (run),
    .load     (load),
    .div      (ld_div),
    .last     (last),
    .div_out  (div_out),
    .div_tick (div_tick)
  );
endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb_clk_div_ctrl: scoreboard bench. Each driven cycle pushes the expected
// outputs of the following clock cycle; the monitor samples div_out in both
// clock halves plus tick/busy/ready/err and pops one entry per cycle.
module tb_clk_div_ctrl;
  logic clk = 1'b0;
  logic reset;
  logic div_out, div_tick, busy;

  clk_div_ctrl_if #(.CNT_W(8)) cfg ();

  clk_div_ctrl #(.CNT_W(8), .DIV_RESET(3)) dut (
    .clk      (clk),
    .reset    (reset),
    .cfg      (cfg),
    .div_out  (div_out),
    .div_tick (div_tick),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    bit chk;
    bit d1, d2, tk, bsy, rdy, err;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   bn, bc;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s @%0t: got %0d want %0d", tag, $time, got, want);
    end
  endtask

  function automatic exp_t e_run(input int n, input int c, input bit rdy);
    exp_t e;
    int   h = n / 2;
    e.chk = 1'b1;
    e.d1  = (c < h) || ((n % 2 == 1) && (c == h));
    e.d2  = (c < h);
    e.tk  = (c == n - 1);
    e.bsy = 1'b1;
    e.rdy = rdy;
    e.err = 1'b0;
    return e;
  endfunction

  function automatic exp_t e_idle(input bit rdy, input bit err);
    exp_t e;
    e     = '0;
    e.chk = 1'b1;
    e.rdy = rdy;
    e.err = err;
    return e;
  endfunction

  // Inputs set here are sampled at the next rising edge; e describes the
  // cycle that edge starts.
  task automatic step(input bit v, input bit en, input int d, input exp_t e);
    cfg.cfg_valid = v;
    cfg.cfg_en    = en;
    cfg.cfg_div   = d[7:0];
    q.push_back(e);
    @(negedge clk);
    #2;
  endtask

  task automatic run_for(input int k, input bit rdy);
    for (int i = 0; i < k; i++) begin
      bc = (bc + 1) % bn;
      step(1'b0, 1'b0, 0, e_run(bn, bc, rdy));
    end
  endtask

  task automatic run_until(input int target);
    while (bc != target) run_for(1, 1'b1);
  endtask

  // Monitor
  initial begin
    exp_t e;
    logic a1, a2, tk, bs, rd, er;
    forever begin
      @(posedge clk);
      #1;
      a1 = div_out; tk = div_tick; bs = busy; rd = cfg.cfg_ready; er = cfg.cfg_err;
      @(negedge clk);
      #1;
      a2 = div_out;
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.chk) begin
          chk("div_out_hi_half", {7'd0, a1}, {7'd0, e.d1});
          chk("div_out_lo_half", {7'd0, a2}, {7'd0, e.d2});
          chk("div_tick",        {7'd0, tk}, {7'd0, e.tk});
          chk("busy",            {7'd0, bs}, {7'd0, e.bsy});
          chk("cfg_ready",       {7'd0, rd}, {7'd0, e.rdy});
          chk("cfg_err",         {7'd0, er}, {7'd0, e.err});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    exp_t nc;
    nc = '0;
    reset = 1'b1;
    cfg.cfg_valid = 1'b0; cfg.cfg_en = 1'b0; cfg.cfg_div = '0;
    step(1'b0, 1'b0, 0, nc);
    step(1'b0, 1'b0, 0, e_idle(1'b0, 1'b0));
    reset = 1'b0;
    step(1'b0, 1'b0, 0, e_idle(1'b1, 1'b0));

    // 1: N=3 from idle
    step(1'b1, 1'b1, 3, e_run(3, 0, 1'b1)); bn = 3; bc = 0;
    run_for(8, 1'b1);

    // 2: change at boundary to N=4, then mid-period request for N=5
    run_until(2);
    step(1'b1, 1'b1, 4, e_run(4, 0, 1'b1)); bn = 4; bc = 0;
    run_for(5, 1'b1);
    step(1'b1, 1'b1, 5, e_run(4, 2, 1'b0)); bc = 2;
    step(1'b1, 1'b0, 9, e_run(4, 3, 1'b0)); bc = 3;
    step(1'b0, 1'b0, 0, e_run(5, 0, 1'b1)); bn = 5; bc = 0;
    run_for(10, 1'b1);

    // 3: N=6, stop at cnt=2 -> drain then idle
    run_until(4);
    step(1'b1, 1'b1, 6, e_run(6, 0, 1'b1)); bn = 6; bc = 0;
    run_for(2, 1'b1);
    step(1'b1, 1'b0, 0, e_run(6, 3, 1'b0)); bc = 3;
    run_for(2, 1'b0);
    step(1'b0, 1'b0, 0, e_idle(1'b1, 1'b0));
    step(1'b0, 1'b0, 0, e_idle(1'b1, 1'b0));

    // 4: illegal divisors and a stop while idle
    step(1'b1, 1'b1, 1, e_idle(1'b1, 1'b1));
    step(1'b1, 1'b1, 0, e_idle(1'b1, 1'b1));
    step(1'b1, 1'b0, 5, e_idle(1'b1, 1'b0));
    step(1'b0, 1'b0, 0, e_idle(1'b1, 1'b0));

    // 5: N=2, then N=255, stop on last cycle
    step(1'b1, 1'b1, 2, e_run(2, 0, 1'b1)); bn = 2; bc = 0;
    run_for(6, 1'b1);
    run_until(1);
    step(1'b1, 1'b1, 255, e_run(255, 0, 1'b1)); bn = 255; bc = 0;
    run_for(300, 1'b1);
    run_until(254);
    step(1'b1, 1'b0, 0, e_idle(1'b1, 1'b0));
    step(1'b0, 1'b0, 0, e_idle(1'b1, 1'b0));

    // 6: reset mid-PEND discards the pending divisor
    step(1'b1, 1'b1, 7, e_run(7, 0, 1'b1)); bn = 7; bc = 0;
    run_for(2, 1'b1);
    step(1'b1, 1'b1, 3, e_run(7, 3, 1'b0)); bc = 3;
    run_for(1, 1'b0);
    reset = 1'b1;
    step(1'b0, 1'b0, 0, e_idle(1'b0, 1'b0));
    reset = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 0, e_idle(1'b1, 1'b0));
    step(1'b1, 1'b1, 3, e_run(3, 0, 1'b1)); bn = 3; bc = 0;
    run_for(6, 1'b1);

    repeat (2) @(negedge clk);
    #2;
    chk("scoreboard_empty", q.size() > 255 ? 8'd255 : 8'(q.size()), 8'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
